// File: rtl/mips_ins_mem_boot_loader.sv
// Instruction memory for the single-cycle MIPS core, with a boot loader in front of it.
// A program arrives over a valid/ready word stream and is written into the word array.
// The core is held in reset until the load completes, then released after a fixed delay.
// Fetches are combinational. Anything outside the loaded program returns 0, which is a NOP.
module mips_ins_mem_boot_loader #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_DEPTH     = 64,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           LD_VALID,
    input  logic [DATA_WIDTH-1:0]          LD_DATA,
    input  logic                           LD_LAST,
    output logic                           LD_READY,
    input  logic [ADDR_WIDTH-1:0]          PC_to_ins_mem,
    output logic [DATA_WIDTH-1:0]          ins_mem_RD,
    output logic                           CORE_RST_N,
    output logic                           LOAD_DONE,
    output logic                           LOAD_ERR,
    output logic [$clog2(MEM_DEPTH+1)-1:0] WORD_COUNT
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned CntW = $clog2(MEM_DEPTH + 1);
    localparam int unsigned DlyW = $clog2(RELEASE_DELAY + 1);

    typedef enum logic [1:0] {
        StLoad,
        StHold,
        StRun,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       word_count_q, word_count_d;
    logic [DlyW-1:0]       dly_cnt_q, dly_cnt_d;
    logic                  ld_ready_q, ld_ready_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  xfer;
    logic [IdxW-1:0]       rd_idx;
    logic                  pc_hi_zero;
    logic                  unused_pc_lsb;

    assign xfer          = LD_VALID & ld_ready_q;
    assign rd_idx        = PC_to_ins_mem[IdxW+1:2];
    assign pc_hi_zero    = (PC_to_ins_mem >> (IdxW + 2)) == '0;
    // Byte offset within a word has no meaning for word fetches.
    assign unused_pc_lsb = ^PC_to_ins_mem[1:0];

    // Next-state logic for the loader FSM and its registered outputs.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        dly_cnt_d    = dly_cnt_q;

        unique case (state_q)
            StLoad: begin
                if (xfer) begin
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    word_count_d = word_count_q + 1'b1;
                    // LAST on the final slot is a legal full load, so LAST wins.
                    if (LD_LAST) begin
                        state_d = StHold;
                    end else if (wr_ptr_q == IdxW'(MEM_DEPTH - 1)) begin
                        state_d = StErr;
                    end
                end
            end
            StHold: begin
                if (dly_cnt_q == DlyW'(RELEASE_DELAY)) begin
                    state_d = StRun;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            StRun: begin
            end
            StErr: begin
            end
            default: begin
                state_d = StLoad;
            end
        endcase

        // Outputs follow the next state so they are registered alongside it.
        ld_ready_d   = (state_d == StLoad);
        core_rst_n_d = (state_d == StRun);
        load_done_d  = (state_d == StRun);
        load_err_d   = (state_d == StErr);
    end

    // State and control registers; asynchronous reset returns everything to LOAD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StLoad;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            dly_cnt_q    <= '0;
            ld_ready_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            dly_cnt_q    <= dly_cnt_d;
            ld_ready_q   <= ld_ready_d;
            core_rst_n_q <= core_rst_n_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    // Program array write port; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (xfer) begin
            mem_q[wr_ptr_q] <= LD_DATA;
        end
    end

    // Combinational fetch. Fetches return NOP unless the core is running and the
    // address falls inside the loaded program.
    always_comb begin
        ins_mem_RD = '0;
        if ((state_q == StRun) && pc_hi_zero && (CntW'(rd_idx) < word_count_q)) begin
            ins_mem_RD = mem_q[rd_idx];
        end
    end

    assign LD_READY   = ld_ready_q;
    assign CORE_RST_N = core_rst_n_q;
    assign LOAD_DONE  = load_done_q;
    assign LOAD_ERR   = load_err_q;
    assign WORD_COUNT = word_count_q;

endmodule

// File: tb/tb_mips_ins_mem_boot_loader.sv
// Bench for the boot-loading instruction memory. Two instances share the stimulus:
// u_dut64 uses the default depth, and u_dut4 uses a 4-word array for the overflow and full-load cases.
module tb_mips_ins_mem_boot_loader;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] exp;
    } fetch_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        LD_VALID;
    logic        LD_LAST;
    logic [31:0] LD_DATA;
    logic [31:0] PC;

    logic        a_ready, a_crst, a_done, a_err;
    logic [31:0] a_rd;
    logic [6:0]  a_wc;
    logic        b_ready, b_crst, b_done, b_err;
    logic [31:0] b_rd;
    logic [2:0]  b_wc;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_q [$];
    fetch_t      fetch_q [$];

    always #5 CLK = ~CLK;

    mips_ins_mem_boot_loader #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .MEM_DEPTH    (64),
        .RELEASE_DELAY(4)
    ) u_dut64 (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .LD_VALID     (LD_VALID),
        .LD_DATA      (LD_DATA),
        .LD_LAST      (LD_LAST),
        .LD_READY     (a_ready),
        .PC_to_ins_mem(PC),
        .ins_mem_RD   (a_rd),
        .CORE_RST_N   (a_crst),
        .LOAD_DONE    (a_done),
        .LOAD_ERR     (a_err),
        .WORD_COUNT   (a_wc)
    );

    mips_ins_mem_boot_loader #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .MEM_DEPTH    (4),
        .RELEASE_DELAY(4)
    ) u_dut4 (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .LD_VALID     (LD_VALID),
        .LD_DATA      (LD_DATA),
        .LD_LAST      (LD_LAST),
        .LD_READY     (b_ready),
        .PC_to_ins_mem(PC),
        .ins_mem_RD   (b_rd),
        .CORE_RST_N   (b_crst),
        .LOAD_DONE    (b_done),
        .LOAD_ERR     (b_err),
        .WORD_COUNT   (b_wc)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        RST_N    = 1'b0;
        #2;
        tick();
        RST_N = 1'b1;
        tick();
        model_q.delete();
    endtask

    // Offer one word and wait, within a bounded number of cycles, for it to be accepted.
    task automatic push_word(input bit sel4, input logic [31:0] d, input bit last,
                             input bit keep_valid);
        bit ok = 1'b0;
        LD_VALID = 1'b1;
        LD_DATA  = d;
        LD_LAST  = last;
        model_q.push_back(d);
        for (int i = 0; i < 16; i++) begin
            if ((sel4 ? b_ready : a_ready) === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: word %h got not-accepted want accepted", d);
        end
        LD_LAST = 1'b0;
        if (keep_valid) LD_DATA = 32'hDEAD_BEEF;
        else            LD_VALID = 1'b0;
    endtask

    // Compute the expected fetch result from the bench model and queue it.
    task automatic issue_fetch(input logic [31:0] pc, input bit run, input int idxw);
        fetch_t      f;
        int          idx;
        logic [31:0] hi;
        idx   = int'((pc >> 2) & ((32'd1 << idxw) - 32'd1));
        hi    = pc >> (idxw + 2);
        f.pc  = pc;
        f.exp = 32'h0;
        if (run && hi == 32'h0 && idx < model_q.size()) f.exp = model_q[idx];
        fetch_q.push_back(f);
    endtask

    task automatic drain_fetches(input bit sel4);
        fetch_t      f;
        logic [31:0] act;
        while (fetch_q.size() > 0) begin
            f  = fetch_q.pop_front();
            PC = f.pc;
            #1;
            act = sel4 ? b_rd : a_rd;
            n_checks++;
            if (act !== f.exp) begin
                n_fail++;
                $display("FAIL fetch pc=%h: got %h want %h", f.pc, act, f.exp);
            end
        end
    endtask

    task automatic test_reset();
        RST_N    = 1'b0;
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        LD_DATA  = 32'h0;
        PC       = 32'h0;
        #12;
        n_checks++;
        if ({a_ready, a_crst, a_done, a_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {a_ready, a_crst, a_done, a_err});
        end
        n_checks++;
        if (a_wc !== 7'd0 || b_wc !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d/%0d want 0/0", a_wc, b_wc);
        end
        n_checks++;
        if (a_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fetch: got %h want 0", a_rd);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        n_checks++;
        if (a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 0", a_ready);
        end
        tick();
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b%b want 11", a_ready, b_ready);
        end
    endtask

    task automatic test_load_release();
        model_q.delete();
        push_word(1'b0, 32'h2008_0005, 1'b0, 1'b0);
        push_word(1'b0, 32'h2009_0007, 1'b0, 1'b0);
        push_word(1'b0, 32'h0109_5020, 1'b1, 1'b0);
        n_checks++;
        if (a_ready !== 1'b0 || a_wc !== 7'd3) begin
            n_fail++;
            $display("FAIL after_last: got ready=%b count=%0d want ready=0 count=3", a_ready, a_wc);
        end
        issue_fetch(32'h0, 1'b0, 6);
        drain_fetches(1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (a_crst !== (k == 5) || a_done !== (k == 5)) begin
                n_fail++;
                $display("FAIL release_edge%0d: got crst=%b done=%b want %b", k, a_crst, a_done,
                         (k == 5));
            end
        end
        issue_fetch(32'h0, 1'b1, 6);
        issue_fetch(32'h4, 1'b1, 6);
        issue_fetch(32'h8, 1'b1, 6);
        issue_fetch(32'hC, 1'b1, 6);
        drain_fetches(1'b0);
    endtask

    task automatic test_valid_gaps();
        apply_reset();
        push_word(1'b0, 32'h2008_0005, 1'b0, 1'b0);
        tick();
        tick();
        push_word(1'b0, 32'h2009_0007, 1'b0, 1'b0);
        tick();
        push_word(1'b0, 32'h0109_5020, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) tick();
        LD_VALID = 1'b0;
        n_checks++;
        if (a_wc !== 7'd3 || a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_count: got count=%0d done=%b want 3/1", a_wc, a_done);
        end
        issue_fetch(32'h0, 1'b1, 6);
        issue_fetch(32'h4, 1'b1, 6);
        issue_fetch(32'h8, 1'b1, 6);
        issue_fetch(32'hC, 1'b1, 6);
        drain_fetches(1'b0);
    endtask

    task automatic test_overflow();
        apply_reset();
        push_word(1'b1, 32'h1111_0001, 1'b0, 1'b0);
        push_word(1'b1, 32'h1111_0002, 1'b0, 1'b0);
        push_word(1'b1, 32'h1111_0003, 1'b0, 1'b0);
        push_word(1'b1, 32'h1111_0004, 1'b0, 1'b0);
        n_checks++;
        if ({b_err, b_crst, b_ready} !== 3'b100 || b_wc !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_state: got err/crst/rdy=%b count=%0d want 100 count=4",
                     {b_err, b_crst, b_ready}, b_wc);
        end
        LD_VALID = 1'b1;
        LD_DATA  = 32'h1111_0005;
        for (int k = 0; k < 3; k++) tick();
        LD_VALID = 1'b0;
        n_checks++;
        if (b_wc !== 3'd4 || b_err !== 1'b1 || b_crst !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_fifth: got count=%0d err=%b crst=%b want 4/1/0", b_wc, b_err,
                     b_crst);
        end
        issue_fetch(32'h0, 1'b0, 2);
        drain_fetches(1'b1);
    endtask

    task automatic test_full_load();
        apply_reset();
        push_word(1'b1, 32'h2222_0001, 1'b0, 1'b0);
        push_word(1'b1, 32'h2222_0002, 1'b0, 1'b0);
        push_word(1'b1, 32'h2222_0003, 1'b0, 1'b0);
        push_word(1'b1, 32'h2222_0004, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (b_done !== 1'b1 || b_err !== 1'b0 || b_crst !== 1'b1 || b_wc !== 3'd4) begin
            n_fail++;
            $display("FAIL full_load: got done=%b err=%b crst=%b count=%0d want 1/0/1/4", b_done,
                     b_err, b_crst, b_wc);
        end
        issue_fetch(32'h0, 1'b1, 2);
        issue_fetch(32'hC, 1'b1, 2);
        issue_fetch(32'h10, 1'b1, 2);
        drain_fetches(1'b1);
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        push_word(1'b0, 32'h3333_0001, 1'b0, 1'b0);
        push_word(1'b0, 32'h3333_0002, 1'b0, 1'b0);
        n_checks++;
        if (a_crst !== 1'b0 || a_wc !== 7'd2) begin
            n_fail++;
            $display("FAIL partial_load: got crst=%b count=%0d want 0/2", a_crst, a_wc);
        end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (a_wc !== 7'd0 || a_crst !== 1'b0 || a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got count=%0d crst=%b rdy=%b want 0/0/0", a_wc, a_crst,
                     a_ready);
        end
        tick();
        RST_N = 1'b1;
        model_q.delete();
        tick();
        push_word(1'b0, 32'h4444_00AA, 1'b0, 1'b0);
        push_word(1'b0, 32'h4444_00BB, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (a_crst !== 1'b0) begin
                n_fail++;
                $display("FAIL reload_hold%0d: got crst=%b want 0", k, a_crst);
            end
        end
        tick();
        n_checks++;
        if (a_crst !== 1'b1 || a_wc !== 7'd2) begin
            n_fail++;
            $display("FAIL reload_run: got crst=%b count=%0d want 1/2", a_crst, a_wc);
        end
        issue_fetch(32'h0, 1'b1, 6);
        issue_fetch(32'h4, 1'b1, 6);
        issue_fetch(32'h8, 1'b1, 6);
        drain_fetches(1'b0);
    endtask

    task automatic test_run_fetch();
        issue_fetch(32'h5, 1'b1, 6);
        issue_fetch(32'h4, 1'b1, 6);
        issue_fetch(32'h8000_0000, 1'b1, 6);
        issue_fetch(32'h0000_0100, 1'b1, 6);
        drain_fetches(1'b0);
        for (int k = 0; k < 3; k++) begin
            LD_VALID = 1'b1;
            LD_LAST  = k[0];
            LD_DATA  = $urandom;
            tick();
            LD_VALID = 1'b0;
            tick();
        end
        LD_LAST = 1'b0;
        n_checks++;
        if (a_wc !== 7'd2 || a_ready !== 1'b0 || a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL run_ignores_load: got count=%0d rdy=%b done=%b want 2/0/1", a_wc,
                     a_ready, a_done);
        end
        // Reset mid-cycle: the core reset must drop without waiting for a clock.
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (a_crst !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got crst=%b done=%b want 0/0", a_crst, a_done);
        end
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_release();
        test_valid_gaps();
        test_overflow();
        test_full_load();
        test_reset_mid_load();
        test_run_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
